// File: rtl/csi_rx_raw10_unpack.sv
// csi_rx_raw10_unpack: unpacks a CSI-2 RAW10 payload word stream into groups of four 10-bit pixels.
// Ports: clock/areset (async, active-high); payload_data/enable/frame and vsync from the packet handler;
// pixel_data/valid/x/y, line_start, line_done/line_residual and frame_start, all registered.
module csi_rx_raw10_unpack #(
   parameter int CW = 16
) (
   input  logic          clock,
   input  logic          areset,
   input  logic [31:0]   payload_data,
   input  logic          payload_enable,
   input  logic          payload_frame,
   input  logic          vsync,
   output logic [39:0]   pixel_data,
   output logic          pixel_valid,
   output logic [CW-1:0] pixel_x,
   output logic [CW-1:0] pixel_y,
   output logic          line_start,
   output logic          line_done,
   output logic [2:0]    line_residual,
   output logic          frame_start
);
   typedef enum logic [1:0] {IDLE, LINE, DRAIN} state_t;
   state_t state_q, state_d;
   logic [63:0] buf_q, buf_d, sh;
   logic [3:0] cnt_q, cnt_d, cnt_s;
   logic first_q, first_d, ext, app;
   logic [CW-1:0] x_q, x_d, px_d, py_d;
   logic [39:0] pd_d, pix;
   logic pv_d, ls_d, ld_d, fs_d;
   logic [2:0] lr_d;
   always_comb begin
      ext = cnt_q >= 4'd5;
      app = payload_enable & payload_frame & (state_q != DRAIN);
      for (int n = 0; n < 4; n++) pix[10*n +: 10] = {buf_q[8*n +: 8], buf_q[32+2*n +: 2]};
      // bytes at or above cnt are always zero, so appending is a plain OR
      sh = ext ? {40'b0, buf_q[63:40]} : buf_q;
      cnt_s = ext ? cnt_q - 4'd5 : cnt_q;
      buf_d = app ? sh | ({32'b0, payload_data} << {cnt_s, 3'b0}) : sh;
      cnt_d = app ? cnt_s + 4'd4 : cnt_s;
      state_d = state_q;
      first_d = ext ? 1'b0 : first_q;
      x_d = ext ? x_q + CW'(4) : x_q;
      pd_d = ext ? pix : pixel_data;
      px_d = ext ? x_q : pixel_x;
      py_d = pixel_y;
      pv_d = ext;
      ls_d = ext & first_q;
      ld_d = 1'b0;
      lr_d = line_residual;
      fs_d = vsync;
      case (state_q)
         IDLE: if (payload_frame) begin
            state_d = LINE;
            first_d = 1'b1;
            x_d = '0;
         end
         LINE: if (!payload_frame) state_d = DRAIN;
         DRAIN: if (!ext) begin
            state_d = IDLE;
            ld_d = 1'b1;
            lr_d = cnt_q[2:0];
            cnt_d = '0;
            buf_d = '0;
            py_d = pixel_y + CW'(1);
         end
         default: state_d = IDLE;
      endcase
      // vsync aborts everything, including a group or line_done due this cycle
      if (vsync) begin
         state_d = IDLE;
         buf_d = '0;
         cnt_d = '0;
         first_d = 1'b0;
         x_d = '0;
         px_d = '0;
         py_d = '0;
         pv_d = 1'b0;
         ls_d = 1'b0;
         ld_d = 1'b0;
      end
   end
   always_ff @(posedge clock or posedge areset) begin
      if (areset) begin
         state_q <= IDLE;
         buf_q <= '0;
         cnt_q <= '0;
         first_q <= 1'b0;
         x_q <= '0;
         pixel_data <= '0;
         pixel_valid <= 1'b0;
         pixel_x <= '0;
         pixel_y <= '0;
         line_start <= 1'b0;
         line_done <= 1'b0;
         line_residual <= '0;
         frame_start <= 1'b0;
      end else begin
         state_q <= state_d;
         buf_q <= buf_d;
         cnt_q <= cnt_d;
         first_q <= first_d;
         x_q <= x_d;
         pixel_data <= pd_d;
         pixel_valid <= pv_d;
         pixel_x <= px_d;
         pixel_y <= py_d;
         line_start <= ls_d;
         line_done <= ld_d;
         line_residual <= lr_d;
         frame_start <= fs_d;
      end
   end
endmodule

// File: tb/tb_csi_rx_raw10_unpack.sv
// tb_csi_rx_raw10_unpack: directed self-checking bench for csi_rx_raw10_unpack.
module tb_csi_rx_raw10_unpack;
   localparam int CW = 16;
   logic clock = 1'b0, areset = 1'b1;
   logic [31:0] payload_data = '0;
   logic payload_enable = 1'b0, payload_frame = 1'b0, vsync = 1'b0;
   logic [39:0] pixel_data;
   logic pixel_valid, line_start, line_done, frame_start;
   logic [CW-1:0] pixel_x, pixel_y;
   logic [2:0] line_residual;
   int tests = 0, fails = 0, cyc = 0, done_cnt = 0, d0 = 0, bad = 0;
   logic [2:0] last_res = '0;
   logic [39:0] got_d[$];
   int got_x[$], got_y[$], got_ls[$], got_c[$], word_c[$];

   csi_rx_raw10_unpack #(.CW(CW)) dut (
      .clock(clock), .areset(areset), .payload_data(payload_data),
      .payload_enable(payload_enable), .payload_frame(payload_frame), .vsync(vsync),
      .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .line_start(line_start), .line_done(line_done), .line_residual(line_residual),
      .frame_start(frame_start)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      cyc++;
      if (pixel_valid) begin
         got_d.push_back(pixel_data);
         got_x.push_back(int'(pixel_x));
         got_y.push_back(int'(pixel_y));
         got_ls.push_back(int'(line_start));
         got_c.push_back(cyc);
      end
      if (line_done) begin
         done_cnt++;
         last_res = line_residual;
         chk("done_not_with_valid", pixel_valid, 0);
      end
   endtask

   task automatic clear_log();
      got_d.delete(); got_x.delete(); got_y.delete(); got_ls.delete(); got_c.delete(); word_c.delete();
   endtask

   function automatic logic [39:0] grp(input int b);
      logic [39:0] r;
      logic [7:0] b4;
      b4 = 8'(b + 4);
      for (int n = 0; n < 4; n++) r[10*n +: 10] = {8'(b + n), b4[2*n +: 2]};
      return r;
   endfunction

   function automatic logic [31:0] wrd(input int b);
      logic [31:0] w;
      for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'(b + k);
      return w;
   endfunction

   task automatic send_line(input int nw, input int base, input bit gap);
      int s;
      payload_frame = 1'b1;
      for (int i = 0; i < nw; i++) begin
         if (gap) begin
            payload_enable = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
         end
         payload_enable = 1'b1;
         payload_data = wrd(base + 4 * i);
         tick();
         word_c.push_back(cyc);
      end
      payload_enable = 1'b0;
      payload_frame = 1'b0;
      s = done_cnt;
      for (int t = 0; t < 6 && done_cnt == s; t++) tick();
      chk("line_done_seen", done_cnt - s, 1);
      tick();
      tick();
   endtask

   initial begin
      repeat (3) tick();
      chk("reset_outputs", {pixel_data, pixel_valid, pixel_x, pixel_y, line_start, line_done, line_residual, frame_start}, 0);
      areset = 1'b0;
      tick();
      // asynchronous reset in the middle of a line
      payload_frame = 1'b1;
      for (int i = 0; i < 3; i++) begin
         payload_enable = 1'b1;
         payload_data = wrd(8'h20 + 4 * i);
         tick();
      end
      chk("valid_before_reset", pixel_valid, 1);
      #2 areset = 1'b1;
      #1 chk("async_reset_outputs", {pixel_data, pixel_valid, pixel_x, pixel_y, line_start, line_done, line_residual, frame_start}, 0);
      payload_enable = 1'b0;
      payload_frame = 1'b0;
      repeat (2) tick();
      areset = 1'b0;
      clear_log();
      repeat (5) tick();
      chk("no_valid_after_reset", got_d.size(), 0);
      // one 20-byte line
      clear_log();
      send_line(5, 0, 1'b0);
      chk("l1_groups", got_d.size(), 4);
      chk("l1_g0_data", got_d[0], 40'h0300801400);
      chk("l1_latency", got_c[0], word_c[1] + 1);
      for (int g = 0; g < 4; g++) begin
         chk($sformatf("l1_data%0d", g), got_d[g], grp(5 * g));
         chk($sformatf("l1_x%0d", g), got_x[g], 4 * g);
         chk($sformatf("l1_ls%0d", g), got_ls[g], g == 0);
         chk($sformatf("l1_y%0d", g), got_y[g], 0);
      end
      chk("l1_residual", last_res, 0);
      chk("l1_y_after", pixel_y, 1);
      clear_log();
      send_line(5, 0, 1'b0);
      chk("l2_groups", got_d.size(), 4);
      for (int g = 0; g < 4; g++) chk($sformatf("l2_y%0d", g), got_y[g], 1);
      chk("l2_g0_data", got_d[0], 40'h0300801400);
      // full-rate line
      clear_log();
      send_line(20, 0, 1'b0);
      chk("fr_groups", got_d.size(), 16);
      bad = 0;
      for (int g = 0; g < 16; g++) if (got_d[g] !== grp(5 * g) || got_x[g] != 4 * g) bad++;
      chk("fr_bad_groups", bad, 0);
      chk("fr_last_x", got_x[15], 60);
      chk("fr_residual", last_res, 0);
      // 12-byte line leaves 2 bytes behind
      clear_log();
      send_line(3, 0, 1'b0);
      chk("res_groups", got_d.size(), 2);
      chk("res_g1_data", got_d[1], grp(5));
      chk("res_residual", last_res, 2);
      clear_log();
      send_line(5, 8'h40, 1'b0);
      chk("after_res_x", got_x[0], 0);
      chk("after_res_ls", got_ls[0], 1);
      chk("after_res_data", got_d[0], grp(8'h40));
      // idle gaps inside the line
      clear_log();
      send_line(5, 0, 1'b1);
      chk("gap_groups", got_d.size(), 4);
      for (int g = 0; g < 4; g++) chk($sformatf("gap_data%0d", g), got_d[g], grp(5 * g));
      // vsync aborting a line
      clear_log();
      d0 = done_cnt;
      payload_frame = 1'b1;
      for (int i = 0; i < 2; i++) begin
         payload_enable = 1'b1;
         payload_data = wrd(8'h60 + 4 * i);
         tick();
      end
      payload_enable = 1'b0;
      tick();
      tick();
      chk("vs_y_nonzero", pixel_y != 0, 1);
      vsync = 1'b1;
      payload_frame = 1'b0;
      tick();
      vsync = 1'b0;
      chk("vs_frame_start", frame_start, 1);
      chk("vs_y_cleared", pixel_y, 0);
      chk("vs_x_cleared", pixel_x, 0);
      tick();
      chk("vs_frame_start_pulse", frame_start, 0);
      repeat (5) tick();
      chk("vs_no_line_done", done_cnt, d0);
      clear_log();
      send_line(5, 8'h80, 1'b0);
      chk("vs_groups", got_d.size(), 4);
      chk("vs_ls", got_ls[0], 1);
      chk("vs_x0", got_x[0], 0);
      chk("vs_y0", got_y[0], 0);
      chk("vs_data0", got_d[0], grp(8'h80));
      chk("vs_data1", got_d[1], grp(8'h85));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/csi_rx_raw10_unpack.md
# csi_rx_raw10_unpack

Unpacks MIPI CSI-2 RAW10 payload into 10-bit pixels. Consumes the 32-bit payload word stream from the CSI-2 receiver's packet handler, in the word clock domain. Emits four pixels per valid cycle, plus per-line and per-frame markers and pixel coordinates. Lines whose byte count is not a multiple of 5 have their trailing bytes discarded and reported.

## Interface

Parameters
- CW, 16, width of the pixel_x / pixel_y coordinate counters.

Ports
- clock  in  1  word clock; receiver's word_clk.
- areset  in  1  asynchronous, active-high reset.
- payload_data  in  32  payload word; byte k = payload_data[8k+7:8k], byte 0 is earliest on the wire.
- payload_enable  in  1  payload_data valid this cycle.
- payload_frame  in  1  high for the duration of a video line payload.
- vsync  in  1  one-cycle frame-start pulse.
- pixel_data  out  40  pixel n (n=0..3) at [10n+9:10n].
- pixel_valid  out  1  pixel_data holds a valid group of 4 pixels.
- pixel_x  out  CW  index of pixel 0 of the current group within its line.
- pixel_y  out  CW  line index within the frame.
- line_start  out  1  high with the first group of a line.
- line_done  out  1  one-cycle pulse after the last group of a line.
- line_residual  out  3  discarded byte count; valid with line_done.
- frame_start  out  1  registered copy of vsync.

## Operation

- Byte buffer: 8 bytes, 64 bits, with count cnt (0..8). Appended bytes go at positions cnt..cnt+3.
- Group extraction: when cnt>=5 at the start of a cycle, the block extracts bytes 0..4 as one group.
  - Pixel n = {byte n, byte4[2n+1:2n]}.
  - The buffer shifts down by 5 bytes.
  - Extraction and append happen in the same cycle.
  - Next count: cnt' = cnt - 5*(cnt>=5) + 4*append.
  - cnt never exceeds 8, so no overflow is possible.
- IDLE state:
  - payload_frame=1 → go to LINE.
  - If payload_enable=1 in the same cycle, append the word.
  - Set first flag and clear the x counter.
- LINE state:
  - Append when payload_enable & payload_frame.
  - Extract whenever cnt>=5.
  - payload_frame=0 → go to DRAIN; payload_enable is ignored from this point.
- DRAIN state:
  - If cnt>=5, extract one group and stay in DRAIN.
  - Otherwise pulse line_done, set line_residual=cnt, clear cnt, increment pixel_y, and go to IDLE.
  - DRAIN lasts at most 2 cycles.
- Words with payload_enable=1 are dropped in these cases:
  - while payload_frame=0;
  - while in DRAIN.
- pixel_x: 0 for the first group of a line, +4 per group. Wraps modulo 2^CW.
- line_start: asserted with the first group emitted after entering LINE.
- vsync (any state):
  - Clear buffer, cnt, pixel_x, pixel_y and the first flag.
  - Go to IDLE; no line_done is issued for an aborted line.
  - Pulse frame_start next cycle.
- vsync together with a completing DRAIN: vsync wins. There is no line_done, and pixel_y=0.

## Timing

- All outputs are registered. Every output and all state are 0 after areset.
- Latency: a word appended at cycle t makes its group (if cnt reaches >=5) visible with pixel_valid at cycle t+2.
- Outputs are pulses, not held:
  - pixel_valid, line_start, line_done and frame_start are single-cycle.
  - pixel_data, pixel_x and pixel_y are held between valid cycles.
- Throughput: one word per cycle indefinitely, with no backpressure.
  - Input rate is 4 bytes/cycle; output rate is 5 bytes/cycle.
- line_done occurs 1–2 cycles after payload_frame falls, and never in the same cycle as pixel_valid.
- pixel_y updates in the same cycle that line_done is asserted; the next line's groups carry the new value.

## Test plan

1. Reset: assert areset mid-stream → all outputs 0 immediately; after release, no pixel_valid until a new line.
2. One line, 5 consecutive words, bytes 0x00..0x13 → 4 groups, then line_done with residual=0.
   - Group 0 pixels = 0x000, 0x005, 0x008, 0x00C.
   - line_start on group 0 only; pixel_x = 0, 4, 8, 12; pixel_y = 0.
   - A second identical line gives pixel_y=1.
3. Full-rate line of 20 back-to-back words → 16 groups on consecutive-compatible cycles with no loss; pixel_x ends at 60; residual=0.
4. Line of 3 words (12 bytes) → 2 groups, then line_done with line_residual=2; the next line starts with cnt=0 (pixel_x=0, correct data).
5. Same stimulus as 2 with a random idle gap between words (payload_enable=0, payload_frame=1) → identical pixel_data sequence.
6. vsync after 2 words of a line → no line_done; frame_start the next cycle; a following line produces line_start, pixel_x=0, pixel_y=0 and clean data.
